gray_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator sitting directly downstream of the RGB-to-grayscale conversion stage. Accepts one 8-bit grayscale pixel per valid cycle in raster order, buffers the two previous image rows in internal line memories, and emits a registered 3x3 window of pixels centred on every interior pixel of the frame. It feeds the filter/edge-detection stages, so they never touch frame memory.

---
 rtl/gray_window_3x3.sv | 115 +++++++++++
 tb/tb_gray_window_3x3.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a shifting
// window register, emitting a registered window for every interior pixel.
module gray_window_3x3 #(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned HEIGHT = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pix_valid,
  input  logic [7:0]                pix_in,
  input  logic                      sof,
  output logic                      win_valid,
  output logic [71:0]               win,
  output logic [$clog2(WIDTH)-1:0]  win_x,
  output logic [$clog2(HEIGHT)-1:0] win_y,
  output logic                      frame_done
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  logic [XW-1:0] col_q, col_d, pos_x;
  logic [YW-1:0] row_q, row_d, pos_y;
  logic [71:0]   shr_q, shr_d;
  logic [71:0]   win_q, win_d;
  logic [XW-1:0] win_x_q, win_x_d;
  logic [YW-1:0] win_y_q, win_y_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [7:0] lb0_q [WIDTH];
  logic [7:0] lb1_q [WIDTH];

  // sof overrides the counters so the pixel lands at (0,0)
  assign pos_x = sof ? '0 : col_q;
  assign pos_y = sof ? '0 : row_q;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    shr_d        = shr_q;
    win_d        = win_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      for (int r = 0; r < 3; r++) begin
        shr_d[8*(3*r)   +: 8] = shr_q[8*(3*r+1) +: 8];
        shr_d[8*(3*r+1) +: 8] = shr_q[8*(3*r+2) +: 8];
      end
      shr_d[8*2 +: 8] = lb0_q[pos_x];
      shr_d[8*5 +: 8] = lb1_q[pos_x];
      shr_d[8*8 +: 8] = pix_in;

      if (pos_x == XW'(WIDTH - 1)) begin
        col_d = '0;
        if (pos_y == YW'(HEIGHT - 1)) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = pos_y + YW'(1);
        end
      end else begin
        col_d = pos_x + XW'(1);
        row_d = pos_y;
      end

      // Only windows whose three rows and columns all belong to this frame
      if (pos_x >= XW'(2) && pos_y >= YW'(2)) begin
        win_valid_d = 1'b1;
        win_d       = shr_d;
        win_x_d     = pos_x - XW'(1);
        win_y_d     = pos_y - YW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      shr_q        <= '0;
      win_q        <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      shr_q        <= shr_d;
      win_q        <= win_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers are read-before-write and deliberately not reset
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb0_q[pos_x] <= lb1_q[pos_x];
      lb1_q[pos_x] <= pix_in;
    end
  end

  assign win_valid  = win_valid_q;
  assign win        = win_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Directed and random bench for gray_window_3x3: a frame-image model pushes
// expected windows to a queue, popped and compared when the DUT emits.
module tb_gray_window_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, v_a, s_a, wv_a, fd_a;
  logic [7:0]  p_a;
  logic [71:0] w_a;
  logic [1:0]  x_a, y_a;

  logic        rst_b, v_b, s_b, wv_b, fd_b;
  logic [7:0]  p_b;
  logic [71:0] w_b;
  logic [6:0]  x_b, y_b;

  gray_window_3x3 #(.WIDTH(4), .HEIGHT(4)) u_small (
    .clk(clk), .rst_n(rst_a), .pix_valid(v_a), .pix_in(p_a), .sof(s_a),
    .win_valid(wv_a), .win(w_a), .win_x(x_a), .win_y(y_a), .frame_done(fd_a)
  );

  gray_window_3x3 u_big (
    .clk(clk), .rst_n(rst_b), .pix_valid(v_b), .pix_in(p_b), .sof(s_b),
    .win_valid(wv_b), .win(w_b), .win_x(x_b), .win_y(y_b), .frame_done(fd_b)
  );

  typedef struct packed {
    logic [71:0] w;
    logic [6:0]  x;
    logic [6:0]  y;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  img [100][100];
  int          n_cmp, n_err;
  int          mcol, mrow;
  int          win_cnt, fd_cnt, xmin, xmax, ymin, ymax;
  logic [71:0] win_first, win_last;
  bit          got_first;

  localparam logic [71:0] WIN11 = {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] WIN22 = {8'd51, 8'd50, 8'd49, 8'd35, 8'd34, 8'd33, 8'd19, 8'd18, 8'd17};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_test();
    sb.delete();
    win_cnt = 0; fd_cnt = 0; got_first = 1'b0;
    xmin = 1000; xmax = -1; ymin = 1000; ymax = -1;
  endtask

  // One clock: update model, drive inputs, check outputs 1 time unit after the edge
  task automatic step(input bit big, input bit v, input logic [7:0] p, input bit s);
    int          w, h, px, py;
    bit          ewv, efd;
    exp_t        e;
    logic        ov, ofd;
    logic [71:0] ow;
    logic [6:0]  ox, oy;
    w = big ? 100 : 4;
    h = w;
    ewv = 1'b0; efd = 1'b0;
    if (v) begin
      px = s ? 0 : mcol;
      py = s ? 0 : mrow;
      img[py][px] = p;
      if (px >= 2 && py >= 2) begin
        ewv = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.w[8*(3*r+c) +: 8] = img[py-2+r][px-2+c];
        e.x = 7'(px - 1);
        e.y = 7'(py - 1);
        sb.push_back(e);
      end
      efd = (px == w-1) && (py == h-1);
      if (px == w-1) begin
        mcol = 0;
        mrow = (py == h-1) ? 0 : py + 1;
      end else begin
        mcol = px + 1;
        mrow = py;
      end
    end
    if (big) begin v_b = v; p_b = p; s_b = s; end
    else     begin v_a = v; p_a = p; s_a = s; end
    @(posedge clk);
    #1;
    if (big) begin ov = wv_b; ofd = fd_b; ow = w_b; ox = x_b; oy = y_b; end
    else     begin ov = wv_a; ofd = fd_a; ow = w_a; ox = {5'd0, x_a}; oy = {5'd0, y_a}; end
    chk("win_valid", 72'(ov), 72'(ewv));
    chk("frame_done", 72'(ofd), 72'(efd));
    if (ov) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $error("FAIL scoreboard_empty observed=window expected=none");
      end else begin
        e = sb.pop_front();
        chk("win", ow, e.w);
        chk("win_x", 72'(ox), 72'(e.x));
        chk("win_y", 72'(oy), 72'(e.y));
        win_cnt++;
        if (!got_first) begin win_first = ow; got_first = 1'b1; end
        win_last = ow;
        if (int'(ox) < xmin) xmin = int'(ox);
        if (int'(ox) > xmax) xmax = int'(ox);
        if (int'(oy) < ymin) ymin = int'(oy);
        if (int'(oy) > ymax) ymax = int'(oy);
      end
    end
    if (ofd) fd_cnt++;
  endtask

  task automatic chk_reset_small(input string tag);
    chk({tag, "_win_valid"}, 72'(wv_a), 72'(0));
    chk({tag, "_frame_done"}, 72'(fd_a), 72'(0));
    chk({tag, "_win"}, w_a, 72'(0));
    chk({tag, "_win_x"}, 72'(x_a), 72'(0));
    chk({tag, "_win_y"}, 72'(y_a), 72'(0));
  endtask

  task automatic end_test(input string tag, input int nwin, input int nfd);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk({tag, "_windows"}, 72'(win_cnt), 72'(nwin));
    chk({tag, "_frame_done_cnt"}, 72'(fd_cnt), 72'(nfd));
    chk({tag, "_queue_drained"}, 72'(sb.size()), 72'(0));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; mcol = 0; mrow = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    v_a = 1'b0; p_a = 8'd0; s_a = 1'b0;
    v_b = 1'b0; p_b = 8'd0; s_b = 1'b0;
    #12;
    chk_reset_small("reset");
    chk("reset_big_win_valid", 72'(wv_b), 72'(0));
    chk("reset_big_win", w_b, 72'(0));
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // Continuous frame
    start_test();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        step(1'b0, 1'b1, 8'(16*y + x), (x == 0 && y == 0));
    end_test("cont", 4, 1);
    chk("cont_win11", win_first, WIN11);
    chk("cont_win22", win_last, WIN22);

    // Valid toggling every cycle
    start_test();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        step(1'b0, 1'b1, 8'(16*y + x), (x == 0 && y == 0));
        step(1'b0, 1'b0, 8'hff, 1'b0);
      end
    end_test("gaps", 4, 1);
    chk("gaps_win11", win_first, WIN11);
    chk("gaps_win22", win_last, WIN22);

    // Two back-to-back frames
    start_test();
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++)
          step(1'b0, 1'b1, (f == 0) ? 8'(16*y + x) : 8'(200 - (16*y + x)), (x == 0 && y == 0));
    end_test("b2b", 8, 2);
    chk("b2b_last_win", win_last,
        {8'd149, 8'd150, 8'd151, 8'd165, 8'd166, 8'd167, 8'd181, 8'd182, 8'd183});

    // sof at (1,2) abandons the frame
    start_test();
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, 8'(16*(i/4) + (i%4)), (i == 0));
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        step(1'b0, 1'b1, 8'(100 + 16*y + x), (x == 0 && y == 0));
    end_test("abandon", 4, 1);

    // Reset in the middle of row 2
    start_test();
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 8'(16*(i/4) + (i%4)), (i == 0));
    v_a = 1'b0;
    rst_a = 1'b0;
    #1;
    chk_reset_small("midrst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_small("midrst_hold");
    rst_a = 1'b1;
    mcol = 0; mrow = 0;
    sb.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        step(1'b0, 1'b1, 8'(16*y + x), 1'b0);
    end_test("midrst", 4, 1);
    chk("midrst_win22", win_last, WIN22);

    // Full-size random frame
    start_test();
    mcol = 0; mrow = 0;
    for (int i = 0; i < 10000; i++)
      step(1'b1, 1'b1, 8'($urandom_range(255)), (i == 0));
    step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("big_windows", 72'(win_cnt), 72'(9604));
    chk("big_frame_done_cnt", 72'(fd_cnt), 72'(1));
    chk("big_xmin", 72'(xmin), 72'(1));
    chk("big_xmax", 72'(xmax), 72'(98));
    chk("big_ymin", 72'(ymin), 72'(1));
    chk("big_ymax", 72'(ymax), 72'(98));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
